// File: rtl/expr_alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit expression evaluator among three lanes.
// Add/sub/mul finish in EXEC; divide runs a 4-step restoring divider in DIV.
module expr_alu_arbiter #(
    parameter logic [9:0] DZ_VAL = 10'h3FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] exp0,
    input  logic [11:0] exp1,
    input  logic [11:0] exp2,
    input  logic [2:0]  flush,
    output logic [2:0]  ack,
    output logic [9:0]  ans,
    output logic [1:0]  ans_lane,
    output logic        ans_valid,
    output logic        err,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request; only state that grants
    // EXEC  | evaluate captured expression, or set up the divider
    // DIV   | one restoring-divide quotient bit per edge, 4 edges
    // DONE  | one-cycle result strobe and ack to the granted lane
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_lane;
    logic [11:0] r_opnd;
    logic [3:0]  r_div_rem;
    logic [3:0]  r_div_quo;
    logic [1:0]  r_div_cnt;
    logic [9:0]  r_ans;
    logic [1:0]  r_ans_lane;
    logic        r_err;

    logic [1:0]  w_rr_l0;
    logic [1:0]  w_rr_l1;
    logic [1:0]  w_rr_l2;
    logic [1:0]  w_grant_lane;
    logic [11:0] w_exp_sel;
    logic [3:0]  w_a;
    logic [3:0]  w_op;
    logic [3:0]  w_b;
    logic        w_flush_hit;
    logic        w_div_start;
    logic [9:0]  w_exec_res;
    logic        w_exec_err;
    logic [4:0]  w_div_shift;
    logic        w_div_ge;
    logic [3:0]  w_div_rem_nxt;
    logic [3:0]  w_div_quo_nxt;

    function automatic logic [1:0] f_next(input logic [1:0] lane);
        return (lane == 2'd2) ? 2'd0 : lane + 2'd1;
    endfunction

    // Search order starts one past the last granted lane.
    always_comb begin
        w_rr_l0      = f_next(r_last_grant);
        w_rr_l1      = f_next(w_rr_l0);
        w_rr_l2      = f_next(w_rr_l1);
        w_grant_lane = w_rr_l2;
        if (req[w_rr_l0]) begin
            w_grant_lane = w_rr_l0;
        end else if (req[w_rr_l1]) begin
            w_grant_lane = w_rr_l1;
        end
    end

    always_comb begin
        case (w_grant_lane)
            2'd0:    w_exp_sel = exp0;
            2'd1:    w_exp_sel = exp1;
            default: w_exp_sel = exp2;
        endcase
    end

    assign w_a         = r_opnd[11:8];
    assign w_op        = r_opnd[7:4];
    assign w_b         = r_opnd[3:0];
    assign w_flush_hit = flush[r_lane];
    assign w_div_start = (w_op == OP_DIV) && (w_b != 4'd0);

    always_comb begin
        w_exec_res = 10'd0;
        w_exec_err = 1'b0;
        case (w_op)
            OP_ADD: w_exec_res = 10'(w_a) + 10'(w_b);
            OP_SUB: w_exec_res = 10'(w_a) - 10'(w_b);
            OP_MUL: w_exec_res = 10'(w_a) * 10'(w_b);
            OP_DIV: begin
                w_exec_res = DZ_VAL;
                w_exec_err = 1'b1;
            end
            default: begin
                w_exec_res = 10'd0;
                w_exec_err = 1'b1;
            end
        endcase
    end

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    assign w_div_shift   = {r_div_rem, r_div_quo[3]};
    assign w_div_ge      = (w_div_shift >= {1'b0, w_b});
    assign w_div_rem_nxt = w_div_ge ? 4'(w_div_shift - {1'b0, w_b}) : w_div_shift[3:0];
    assign w_div_quo_nxt = {r_div_quo[2:0], w_div_ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req != 3'b000) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_flush_hit)      w_state_nxt = S_IDLE;
                else if (w_div_start) w_state_nxt = S_DIV;
                else                  w_state_nxt = S_DONE;
            end
            S_DIV: begin
                if (w_flush_hit)             w_state_nxt = S_IDLE;
                else if (r_div_cnt == 2'd0)  w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results are written only on the edge that enters DONE, so an abort leaves ans untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 2'd2;
            r_lane       <= 2'd0;
            r_opnd       <= 12'd0;
            r_div_rem    <= 4'd0;
            r_div_quo    <= 4'd0;
            r_div_cnt    <= 2'd0;
            r_ans        <= 10'd0;
            r_ans_lane   <= 2'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req != 3'b000) begin
                        r_lane       <= w_grant_lane;
                        r_last_grant <= w_grant_lane;
                        r_opnd       <= w_exp_sel;
                    end
                end
                S_EXEC: begin
                    if (!w_flush_hit) begin
                        if (w_div_start) begin
                            r_div_rem <= 4'd0;
                            r_div_quo <= w_a;
                            r_div_cnt <= 2'd3;
                        end else begin
                            r_ans      <= w_exec_res;
                            r_err      <= w_exec_err;
                            r_ans_lane <= r_lane;
                        end
                    end
                end
                S_DIV: begin
                    if (!w_flush_hit) begin
                        r_div_rem <= w_div_rem_nxt;
                        r_div_quo <= w_div_quo_nxt;
                        r_div_cnt <= r_div_cnt - 2'd1;
                        if (r_div_cnt == 2'd0) begin
                            r_ans      <= {6'd0, w_div_quo_nxt};
                            r_err      <= 1'b0;
                            r_ans_lane <= r_lane;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ans       = r_ans;
    assign ans_lane  = r_ans_lane;
    assign ans_valid = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_err;
    assign ack       = (r_state == S_DONE) ? (3'b001 << r_lane) : 3'b000;
    assign busy      = (r_state != S_IDLE);

endmodule
